// File: rtl/mario_motion.sv
// rtl/mario_motion.sv - per-frame Mario movement and state engine
// Turns buttons, ladder and hazard flags into sprite centre and state code, once per frame_tick.
module mario_motion #(
  parameter logic [9:0] START_X     = 10'd80,
  parameter logic [8:0] START_Y     = 9'd390,
  parameter logic [9:0] MIN_X       = 10'd80,
  parameter logic [9:0] MAX_X       = 10'd560,
  parameter logic [8:0] TOP_Y       = 9'd90,
  parameter logic [8:0] FLOOR_Y     = 9'd390,
  parameter int         WALK_V      = 4,
  parameter int         CLIMB_V     = 2,
  parameter int         JUMP_V      = 12,
  parameter int         GRAVITY     = 1,
  parameter int         INIT_FRAMES = 30,
  parameter int         DIE_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       on_ladder,
  input  logic       hit,
  output logic [9:0] posX,
  output logic [8:0] posY,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_INITIAL  = 3'b000,
    S_FLYING   = 3'b001,
    S_JUMPING  = 3'b010,
    S_WALKING  = 3'b011,
    S_STANDING = 3'b100,
    S_DYING    = 3'b101,
    S_CLAMPING = 3'b110
  } mstate_t;

  localparam logic signed [10:0] XMIN    = $signed({1'b0, MIN_X});
  localparam logic signed [10:0] XMAX    = $signed({1'b0, MAX_X});
  localparam logic signed [10:0] YTOP    = $signed({2'b00, TOP_Y});
  localparam logic signed [10:0] YFLR    = $signed({2'b00, FLOOR_Y});
  localparam logic signed [5:0]  VY_MAX  = 6'sd15;
  localparam logic signed [5:0]  VY_JUMP = 6'(-JUMP_V);
  localparam logic signed [5:0]  GRAV    = 6'(GRAVITY);
  localparam logic [5:0]         INIT_LAST = 6'(INIT_FRAMES - 1);
  localparam logic [5:0]         DIE_LAST  = 6'(DIE_FRAMES - 1);

  mstate_t            st;
  logic signed [5:0]  vy;
  logic [5:0]         cnt;

  logic signed [10:0] hx;
  logic signed [10:0] dy_clb;
  logic signed [10:0] x_sum;
  logic signed [10:0] y_air_sum;
  logic signed [10:0] y_clb_sum;
  logic signed [5:0]  vy_sum;
  logic signed [5:0]  vy_next;
  logic [9:0]         x_lim;
  logic [8:0]         y_air_lim;
  logic [8:0]         y_clb_lim;

  function automatic logic [9:0] clamp_x(input logic signed [10:0] v);
    if (v < XMIN)      return MIN_X;
    else if (v > XMAX) return MAX_X;
    else               return v[9:0];
  endfunction

  function automatic logic [8:0] clamp_y(input logic signed [10:0] v);
    if (v < YTOP)      return TOP_Y;
    else if (v > YFLR) return FLOOR_Y;
    else               return v[8:0];
  endfunction

  // Sums are formed in signed 11 bits so a step past an edge clamps instead of wrapping.
  always_comb begin
    hx = '0;
    if (btn_right && !btn_left)      hx = 11'(WALK_V);
    else if (btn_left && !btn_right) hx = -11'(WALK_V);
    dy_clb = '0;
    if (btn_up && !btn_down)         dy_clb = -11'(CLIMB_V);
    else if (btn_down && !btn_up)    dy_clb = 11'(CLIMB_V);
    vy_sum    = vy + GRAV;
    vy_next   = (vy_sum > VY_MAX) ? VY_MAX : vy_sum;
    x_sum     = $signed({1'b0, posX}) + hx;
    y_air_sum = $signed({2'b00, posY}) + $signed({{5{vy_next[5]}}, vy_next});
    y_clb_sum = $signed({2'b00, posY}) + dy_clb;
    x_lim     = clamp_x(x_sum);
    y_air_lim = clamp_y(y_air_sum);
    y_clb_lim = clamp_y(y_clb_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= S_INITIAL;
      posX <= START_X;
      posY <= START_Y;
      vy   <= '0;
      cnt  <= '0;
    end else if (frame_tick) begin
      if (hit && st != S_INITIAL && st != S_DYING) begin
        st  <= S_DYING;
        cnt <= '0;
        vy  <= '0;
      end else begin
        case (st)
          S_INITIAL: begin
            if (cnt == INIT_LAST) begin
              st  <= S_STANDING;
              cnt <= '0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          S_DYING: begin
            if (cnt == DIE_LAST) begin
              st   <= S_INITIAL;
              cnt  <= '0;
              vy   <= '0;
              posX <= START_X;
              posY <= START_Y;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          S_STANDING, S_WALKING: begin
            if (on_ladder && (btn_up ^ btn_down)) begin
              st <= S_CLAMPING;
            end else if (btn_jump) begin
              st   <= S_JUMPING;
              vy   <= VY_JUMP;
              posX <= x_lim;
            end else if (hx != 11'sd0) begin
              st   <= S_WALKING;
              posX <= x_lim;
            end else begin
              st <= S_STANDING;
            end
          end
          S_JUMPING, S_FLYING: begin
            posX <= x_lim;
            if (y_air_sum <= YTOP) begin
              posY <= TOP_Y;
              vy   <= '0;
              st   <= S_FLYING;
            end else if (y_air_sum >= YFLR) begin
              posY <= FLOOR_Y;
              vy   <= '0;
              st   <= S_STANDING;
            end else begin
              posY <= y_air_lim;
              vy   <= vy_next;
              if (vy_next >= 6'sd0) st <= S_FLYING;
            end
          end
          S_CLAMPING: begin
            // Leaving the ladder uses the post-move height to decide between landing and falling.
            posY <= y_clb_lim;
            if (!on_ladder) begin
              vy <= '0;
              st <= (y_clb_lim == FLOOR_Y) ? S_STANDING : S_FLYING;
            end
          end
          default: st <= S_INITIAL;
        endcase
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_mario_motion.sv
// tb/tb_mario_motion.sv - self-checking bench for mario_motion
// Directed scenarios plus random frames, compared against a frame-level integer model.
module tb_mario_motion;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       btn_left, btn_right, btn_jump, btn_up, btn_down, on_ladder, hit;
  logic [9:0] posX;
  logic [8:0] posY;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int ms, mx, my, mvy, mc;

  always #5 clk = ~clk;

  mario_motion dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .btn_up(btn_up), .btn_down(btn_down), .on_ladder(on_ladder), .hit(hit),
    .posX(posX), .posY(posY), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    ms = 0; mx = 80; my = 390; mvy = 0; mc = 0;
  endtask

  // One frame of the game rules in plain integers; state codes as the renderer sees them.
  task automatic model_step();
    int hx, ny;
    hx = (btn_right && !btn_left) ? 4 : (btn_left && !btn_right) ? -4 : 0;
    if (hit && ms != 0 && ms != 5) begin
      ms = 5; mc = 0; mvy = 0;
    end else if (ms == 0) begin
      if (mc == 29) begin ms = 4; mc = 0; end else mc++;
    end else if (ms == 5) begin
      if (mc == 59) begin ms = 0; mc = 0; mx = 80; my = 390; mvy = 0; end else mc++;
    end else if (ms == 3 || ms == 4) begin
      if (on_ladder && (btn_up != btn_down)) ms = 6;
      else if (btn_jump) begin ms = 2; mvy = -12; mx = clampi(mx + hx, 80, 560); end
      else if (hx != 0) begin ms = 3; mx = clampi(mx + hx, 80, 560); end
      else ms = 4;
    end else if (ms == 1 || ms == 2) begin
      mx = clampi(mx + hx, 80, 560);
      mvy = (mvy + 1 > 15) ? 15 : mvy + 1;
      ny = my + mvy;
      if (ny <= 90) begin my = 90; mvy = 0; ms = 1; end
      else if (ny >= 390) begin my = 390; mvy = 0; ms = 4; end
      else begin my = ny; if (mvy >= 0) ms = 1; end
    end else if (ms == 6) begin
      ny = my;
      if (btn_up && !btn_down) ny = my - 2;
      else if (btn_down && !btn_up) ny = my + 2;
      my = clampi(ny, 90, 390);
      if (!on_ladder) begin mvy = 0; ms = (my == 390) ? 4 : 1; end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"}, state, ms);
    chk({tag, ".posX"}, posX, mx);
    chk({tag, ".posY"}, posY, my);
  endtask

  task automatic set_in(input logic l, r, j, u, d, lad, h);
    btn_left = l; btn_right = r; btn_jump = j; btn_up = u; btn_down = d;
    on_ladder = lad; hit = h;
  endtask

  task automatic do_tick(input string tag);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    model_step();
    check_model(tag);
  endtask

  // Clock edges without frame_tick while inputs wiggle: nothing may move.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      check_model("idle");
    end
  endtask

  initial begin
    frame_tick = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.state", state, 3'b000);
    chk("reset.posX", posX, 80);
    chk("reset.posY", posY, 390);
    rst_n = 1'b1;
    idle(3);
    set_in(0, 0, 0, 0, 0, 0, 0);

    // INITIAL holds for 29 frames, STANDING after the 30th
    for (int i = 1; i <= 30; i++) begin
      set_in(0, 0, 0, 0, 0, 0, (i == 10));
      do_tick("init");
      if (i == 29) chk("init.t29", state, 3'b000);
    end
    chk("init.done", state, 3'b100);

    // walking right and the right wall
    set_in(0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 140; i++) begin
      do_tick("walk");
      if (i == 5) begin
        chk("walk5.state", state, 3'b011);
        chk("walk5.posX", posX, 100);
      end
    end
    chk("walk.wall", posX, 560);

    set_in(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) do_tick("walk_left");
    chk("walk_left.posX", posX, 520);

    // jump arc with both direction buttons held
    set_in(1, 1, 1, 0, 0, 0, 0);
    do_tick("jump0");
    chk("jump0.state", state, 3'b010);
    chk("jump0.posY", posY, 390);
    for (int k = 1; k <= 23; k++) begin
      do_tick("jump");
      chk("jump.posX_hold", posX, 520);
      if (k == 1)  begin chk("jump1.posY", posY, 379); chk("jump1.state", state, 3'b010); end
      if (k == 11) chk("jump11.state", state, 3'b010);
      if (k == 12) begin chk("apex.posY", posY, 324); chk("apex.state", state, 3'b001); end
      if (k == 22) chk("jump22.state", state, 3'b001);
      if (k == 23) begin chk("land.posY", posY, 390); chk("land.state", state, 3'b100); end
    end

    // ladder climb then drop off
    set_in(0, 0, 0, 1, 0, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      do_tick("climb");
      if (i == 1) chk("climb1.posY", posY, 390);
    end
    chk("climb.state", state, 3'b110);
    chk("climb.posY", posY, 372);
    set_in(0, 0, 0, 0, 0, 0, 0);
    do_tick("drop");
    chk("drop.state", state, 3'b001);
    for (int i = 1; i <= 6; i++) begin
      do_tick("fall");
      if (i == 5) chk("fall5.posY", posY, 387);
    end
    chk("fall.state", state, 3'b100);
    chk("fall.posY", posY, 390);

    // hazard mid-jump, dying hold, respawn
    set_in(0, 0, 1, 0, 0, 0, 0);
    do_tick("hj0");
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) do_tick("hj");
    set_in(0, 1, 0, 0, 0, 0, 1);
    do_tick("hit");
    chk("hit.state", state, 3'b101);
    chk("hit.posY", posY, 360);
    for (int i = 1; i <= 60; i++) begin
      set_in(0, 1, 1, 0, 0, 0, (i == 20));
      do_tick("dying");
      if (i == 59) begin
        chk("dying59.state", state, 3'b101);
        chk("dying59.posX", posX, 520);
        chk("dying59.posY", posY, 360);
      end
    end
    chk("respawn.state", state, 3'b000);
    chk("respawn.posX", posX, 80);
    chk("respawn.posY", posY, 390);
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) do_tick("init2");

    // random frames against the model
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
             1'($urandom), ($urandom_range(0, 59) == 0));
      do_tick("rand");
      if ($urandom_range(0, 9) == 0) idle(2);
    end

    // asynchronous reset mid-jump, then no leftover vertical speed
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 30; i++) do_tick("init3");
    set_in(0, 0, 1, 0, 0, 0, 0);
    do_tick("aj0");
    set_in(0, 0, 0, 0, 0, 0, 0);
    do_tick("aj1");
    do_tick("aj2");
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.state", state, 3'b000);
    chk("areset.posX", posX, 80);
    chk("areset.posY", posY, 390);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) do_tick("init4");
    set_in(0, 0, 1, 0, 0, 0, 0);
    do_tick("rj0");
    set_in(0, 0, 0, 0, 0, 0, 0);
    do_tick("rj1");
    chk("rejump.posY", posY, 379);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
